// File: rtl/gc_pkg.sv
// Shared definitions for the graphic card framebuffer path: bus FSM encoding,
// pixel packing constants and the default framebuffer base address.
package gc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        TERM = 2'd2
    } gc_state_e;

    localparam int          GC_PIXEL_BITS      = 4;
    localparam int          GC_PIXELS_PER_WORD = 8;
    localparam logic [31:0] GC_FB_BASE_DEFAULT = 32'h0010_0000;

    // Colour bits of pixel p; the fourth bit of each nibble is a spare.
    function automatic logic [2:0] gc_pixel(input logic [31:0] word, input int p);
        return word[p*GC_PIXEL_BITS +: 3];
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Single-port framebuffer RAM: registered read every cycle, per-byte write
// enables, no reset so it maps onto block RAM.
module fb_ram #(
    parameter int MEM_WORDS = 38400,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/wb_framebuffer_slave.sv
// Wishbone classic slave in front of the framebuffer RAM, with programmable
// wait states and error termination for addresses outside the buffer.
module wb_framebuffer_slave
    import gc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = GC_FB_BASE_DEFAULT,
    parameter int          MEM_WORDS = 38400,
    parameter int          LATENCY   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    localparam int          AW       = $clog2(MEM_WORDS);
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * MEM_WORDS);

    gc_state_e   state, state_nxt;
    logic [3:0]  wcnt, wcnt_nxt;
    logic        req, hit, term_entry, ram_we;
    logic [31:0] adr_w, ram_rdata;
    logic [AW-1:0] word_w, ram_addr;

    logic [AW-1:0] word_q;
    logic [31:0]   dat_q;
    logic [3:0]    sel_q;
    logic          we_q, hit_q;

    assign req    = wb_cyc_i & wb_stb_i;
    assign adr_w  = wb_adr_i & ~32'h3;
    // 33-bit compare so a buffer ending at the top of the map cannot wrap.
    assign hit    = ({1'b0, adr_w} >= {1'b0, BASE_ADDR}) && ({1'b0, adr_w} < END_ADDR);
    assign word_w = AW'((adr_w - BASE_ADDR) >> 2);

    // The live address feeds the RAM while idle so read data is ready by TERM.
    assign ram_addr   = (state == IDLE) ? word_w : word_q;
    assign ram_we     = (state == TERM) && we_q && hit_q;
    assign term_entry = (state == WAIT) && wb_cyc_i && (wcnt == 4'd0);

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = WAIT;
                    wcnt_nxt  = 4'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (!wb_cyc_i) begin
                    state_nxt = IDLE;
                end else if (wcnt == 4'd0) begin
                    state_nxt = TERM;
                end else begin
                    wcnt_nxt = wcnt - 4'd1;
                end
            end
            TERM:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            wcnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            word_q <= word_w;
            dat_q  <= wb_dat_i;
            sel_q  <= wb_sel_i;
            we_q   <= wb_we_i;
            hit_q  <= hit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= term_entry && hit_q;
            wb_err_o <= term_entry && !hit_q;
            wb_dat_o <= (term_entry && hit_q && !we_q) ? ram_rdata : '0;
        end
    end

    fb_ram #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .be    (sel_q),
        .wdata (dat_q),
        .rdata (ram_rdata)
    );

endmodule
